// File: rtl/prog_loader.sv
// Program loader: byte-stream frame receiver that fills CPU instruction memory
// with nibbles and releases the CPU once the XOR checksum matches.
module prog_loader #(
  parameter int          ADDR_W = 4,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wdata,
  output logic              cpu_run,
  output logic              done,
  output logic              err
);

  localparam logic [7:0] MAXLEN = 8'(1 << (ADDR_W-1));

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DHI, S_DLO, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] cnt, cnt_d;
  logic [ADDR_W-1:0] len, len_d;
  logic [ADDR_W-1:0] cnt_inc;
  logic [7:0]        csum, csum_d;
  logic [3:0]        lat, lat_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [3:0]        wdata_d;
  logic              rdy;
  logic              acc;
  logic              len_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      len       <= '0;
      csum      <= '0;
      lat       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      len       <= len_d;
      csum      <= csum_d;
      lat       <= lat_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
    end
  end

  assign acc     = in_valid & rdy & ~reload;
  assign cnt_inc = cnt + 1'b1;
  assign len_ok  = (in_data != 8'd0) && (in_data <= MAXLEN);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    len_d   = len;
    csum_d  = csum;
    lat_d   = lat;
    we_d    = 1'b0;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    if (reload) begin
      state_d = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_ERR: begin
          if (acc && in_data == SYNC) begin
            csum_d  = '0;
            cnt_d   = '0;
            state_d = S_LEN;
          end
        end
        S_LEN: begin
          if (acc) begin
            if (len_ok) begin
              len_d   = in_data[ADDR_W-1:0];
              state_d = S_DHI;
            end else begin
              state_d = S_ERR;
            end
          end
        end
        S_DHI: begin
          if (acc) begin
            lat_d   = in_data[3:0];
            csum_d  = csum ^ in_data;
            we_d    = 1'b1;
            addr_d  = {cnt[ADDR_W-2:0], 1'b0};
            wdata_d = in_data[7:4];
            state_d = S_DLO;
          end
        end
        S_DLO: begin
          we_d    = 1'b1;
          addr_d  = {cnt[ADDR_W-2:0], 1'b1};
          wdata_d = lat;
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == len) ? S_CSUM : S_DHI;
        end
        S_CSUM: begin
          if (acc)
            state_d = (in_data == csum) ? S_DONE : S_ERR;
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rdy  = 1'b0;
    done = 1'b0;
    err  = 1'b0;
    unique case (state)
      S_IDLE, S_LEN, S_DHI, S_CSUM: rdy = 1'b1;
      S_ERR: begin
        rdy = 1'b1;
        err = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Hold ready low while reset is asserted so all outputs read zero.
  assign in_ready = rdy & reset;
  assign cpu_run  = done;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed frames plus random frames with random
// gaps, checked against a frame-level reference model.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       reload = 1'b0;
  logic       in_ready;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [3:0] mem_wdata;
  logic       cpu_run;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [7:0] stim[$];
  logic [7:0] exp_w[$];
  logic [7:0] got[$];
  bit         pay[$];
  bit         m_done;
  bit         m_err;

  prog_loader #(.ADDR_W(4), .SYNC(8'hA5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .reload(reload),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_run(cpu_run), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (reset && mem_we) got.push_back({mem_addr, mem_wdata});

  task automatic check(input string tag, input logic [31:0] g,
                       input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, g, e);
    end
  endtask

  // Frame-level model: scan for SYNC, take LEN, expand payload into nibble
  // writes, compare trailing byte with XOR of payload.
  task automatic model();
    int i;
    int len;
    logic [7:0] x;
    logic [7:0] b;
    exp_w.delete();
    pay.delete();
    m_done = 0;
    i = 0;
    while (i < stim.size() && !m_done) begin
      pay.push_back(0);
      if (stim[i] != 8'hA5) begin
        i++;
        continue;
      end
      i++;
      m_err = 0;
      if (i >= stim.size()) break;
      len = int'(stim[i]);
      pay.push_back(0);
      i++;
      if (len < 1 || len > 8) begin
        m_err = 1;
        continue;
      end
      x = 0;
      for (int k = 0; k < len; k++) begin
        if (i >= stim.size()) break;
        b = stim[i];
        pay.push_back(1);
        x ^= b;
        exp_w.push_back(8'((2*k) * 16 + int'(b[7:4])));
        exp_w.push_back(8'((2*k+1) * 16 + int'(b[3:0])));
        i++;
      end
      if (i >= stim.size()) break;
      pay.push_back(0);
      m_done = (stim[i] == x);
      m_err = !m_done;
      i++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap,
                           input bit is_pay);
    int n;
    repeat (gap) begin
      in_valid = 0;
      @(negedge clk);
    end
    in_valid = 1;
    in_data = b;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      check("accept_timeout", 0, 1);
      in_valid = 0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (is_pay) check("ready_lo", in_ready, 0);
  endtask

  task automatic run_frame(input string tag, input int gapmax);
    int g;
    got.delete();
    model();
    foreach (stim[i]) begin
      g = (gapmax == 0) ? 0 : int'($urandom_range(gapmax, 0));
      send_byte(stim[i], g, pay[i]);
    end
    in_valid = 0;
    check({tag, "_done"}, done, m_done);
    check({tag, "_err"}, err, m_err);
    check({tag, "_run"}, cpu_run, m_done);
    repeat (3) @(negedge clk);
    check({tag, "_nwr"}, got.size(), exp_w.size());
    foreach (exp_w[i])
      if (i < got.size()) check({tag, "_wr"}, got[i], exp_w[i]);
  endtask

  task automatic pulse_reload();
    in_valid = 0;
    reload = 1;
    @(negedge clk);
    reload = 0;
    check("rl_done", done, 0);
    check("rl_err", err, 0);
    check("rl_run", cpu_run, 0);
    m_err = 0;
  endtask

  task automatic load_t1(input logic [7:0] cs);
    stim = '{8'hA5, 8'h06, 8'h13, 8'h20, 8'h50,
             8'h30, 8'h40, 8'h70, cs};
  endtask

  logic [7:0] t1w[12];
  int         len;
  logic [7:0] x;
  logic [7:0] b;

  initial begin
    t1w = '{8'h01, 8'h13, 8'h22, 8'h30, 8'h45, 8'h50,
            8'h63, 8'h70, 8'h84, 8'h90, 8'hA7, 8'hB0};
    m_err = 0;
    @(negedge clk);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wd", mem_wdata, 0);
    check("rst_rdy", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_run", cpu_run, 0);
    reset = 1;
    @(negedge clk);

    load_t1(8'h63);
    run_frame("t1", 0);
    foreach (t1w[i])
      if (i < got.size()) check("t1_const", got[i], t1w[i]);

    pulse_reload();

    load_t1(8'h62);
    run_frame("t2a", 0);
    stim = '{8'hA5, 8'h01, 8'h10, 8'h10};
    run_frame("t2b", 0);
    pulse_reload();

    stim = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h9C, 8'h9C};
    run_frame("t3", 1);
    pulse_reload();

    stim = '{8'hA5, 8'h00};
    run_frame("t4a", 0);
    stim = '{8'hA5, 8'h09};
    run_frame("t4b", 0);
    pulse_reload();

    in_valid = 1;
    in_data = 8'hA5;
    reload = 1;
    @(negedge clk);
    reload = 0;
    in_valid = 0;
    stim = '{8'h01, 8'h10, 8'h10};
    run_frame("rl_drop", 0);

    for (int it = 0; it < 25; it++) begin
      pulse_reload();
      stim.delete();
      repeat ($urandom_range(3, 0)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        stim.push_back(b);
      end
      stim.push_back(8'hA5);
      if ($urandom_range(5, 0) == 0) begin
        len = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(255, 9));
        stim.push_back(8'(len));
      end else begin
        len = int'($urandom_range(8, 1));
        stim.push_back(8'(len));
        x = 0;
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom);
          x ^= b;
          stim.push_back(b);
        end
        if ($urandom_range(3, 0) == 0) x ^= 8'(int'($urandom_range(255, 1)));
        stim.push_back(x);
      end
      run_frame("rnd", int'($urandom_range(3, 0)));
    end

    pulse_reload();
    stim = '{8'hA5, 8'h06, 8'h13, 8'h20, 8'h50};
    send_byte(8'hA5, 0, 0);
    send_byte(8'h06, 0, 0);
    send_byte(8'h13, 0, 1);
    send_byte(8'h20, 0, 1);
    send_byte(8'h50, 0, 1);
    in_valid = 0;
    #2 reset = 0;
    #1;
    check("ar_we", mem_we, 0);
    check("ar_rdy", in_ready, 0);
    check("ar_done", done, 0);
    check("ar_err", err, 0);
    check("ar_run", cpu_run, 0);
    check("ar_addr", mem_addr, 0);
    check("ar_wd", mem_wdata, 0);
    @(negedge clk);
    reset = 1;
    m_err = 0;
    @(negedge clk);
    load_t1(8'h63);
    run_frame("t6", 3);
    foreach (t1w[i])
      if (i < got.size()) check("t6_const", got[i], t1w[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
